// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared defaults, scheduler state encoding and flat-matrix indexing for the
// systolic feed scheduler.
package systolic_pkg;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 8;
    localparam int DRAIN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Bit offset of element (r,c) in a row-major flattened N x N matrix.
    function automatic int elem_idx(input int r, input int c,
                                    input int n = N_DEF, input int w = W_DEF);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/systolic_feed_scheduler_if.sv
// Host-side operand/result handshake of the systolic feed scheduler.
interface systolic_feed_scheduler_if #(
    parameter int N = systolic_pkg::N_DEF,
    parameter int W = systolic_pkg::W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [N*N*W-1:0]   matrix_A;
    logic [N*N*W-1:0]   matrix_B;
    logic [N*N*W-1:0]   matrix_C;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_valid, matrix_A, matrix_B, out_ready,
        input  in_ready, matrix_C, out_valid
    );

    modport slave (
        input  in_valid, matrix_A, matrix_B, out_ready,
        output in_ready, matrix_C, out_valid
    );
endinterface

// File: rtl/systolic_feed_scheduler_skew_lane.sv
// One skewed edge lane: waits LANE FEED cycles, then streams its N-element
// vector one element per cycle onto the array edge.
module skew_lane
    import systolic_pkg::*;
#(
    parameter int LANE = 0,
    parameter int N    = N_DEF,
    parameter int W    = W_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           feed,
    input  logic [N*W-1:0] vec,
    output logic [W-1:0]   edge_data,
    output logic           edge_valid
);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(N + 1);

    logic [DW-1:0] passer_ready;
    logic [IW-1:0] passer_index;

    // passer_index == N marks the lane as exhausted until the next start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            passer_ready <= '0;
            passer_index <= IW'(N);
        end else if (start) begin
            passer_ready <= DW'(LANE);
            passer_index <= '0;
        end else if (feed) begin
            if (passer_ready != '0)
                passer_ready <= passer_ready - DW'(1);
            else if (passer_index != IW'(N))
                passer_index <= passer_index + IW'(1);
        end
    end

    assign edge_valid = feed && (passer_ready == '0) && (passer_index != IW'(N));
    assign edge_data  = edge_valid ? vec[int'(passer_index)*W +: W] : '0;

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Job sequencer for the N x N systolic array: latch operands, clear, feed
// skewed edges, wait out the wavefront, then hold the captured product.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ready for an operand pair
//  ST_LOAD  | one-cycle accumulator clear
//  ST_FEED  | skewed edges streaming, t = 0 .. 2N-2
//  ST_DRAIN | edges idle while the last products settle; capture at end
//  ST_DONE  | matrix_C valid, waiting for the consumer
module systolic_feed_scheduler
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int DRAIN = DRAIN_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    systolic_feed_scheduler_if.slave   host,
    output logic [N*W-1:0]             a_edge,
    output logic [N-1:0]               a_edge_valid,
    output logic [N*W-1:0]             b_edge,
    output logic [N-1:0]               b_edge_valid,
    output logic                       acc_clear,
    input  logic [N*N*W-1:0]           array_result,
    output logic                       busy
);
    localparam int TW  = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam int DRW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t             state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N*N*W-1:0]   a_lat;
    logic [N*N*W-1:0]   b_lat;
    logic [N*N*W-1:0]   c_q;
    logic [TW-1:0]      t_cnt;
    logic [DRW-1:0]     drain_cnt;
    logic               lane_start;
    logic               lane_feed;

    assign host.in_ready  = in_ready_q;
    assign host.out_valid = out_valid_q;
    assign host.matrix_C  = c_q;

    assign lane_start = (state == ST_LOAD);
    assign lane_feed  = (state == ST_FEED);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_clear   <= 1'b0;
            busy        <= 1'b0;
            t_cnt       <= '0;
            drain_cnt   <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            c_q         <= '0;
        end else begin
            acc_clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.in_valid) begin
                        a_lat      <= host.matrix_A;
                        b_lat      <= host.matrix_B;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        acc_clear  <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    t_cnt <= '0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (t_cnt == TW'(2*N-2)) begin
                        drain_cnt <= DRW'(DRAIN-1);
                        state     <= ST_DRAIN;
                    end else begin
                        t_cnt <= t_cnt + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        c_q         <= array_result;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DRW'(1);
                    end
                end
                ST_DONE: begin
                    if (host.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // A lane l carries row l of A; B lane l carries column l of B.
    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [N*W-1:0] a_vec;
        logic [N*W-1:0] b_vec;

        for (genvar k = 0; k < N; k++) begin : g_elem
            assign a_vec[k*W +: W] = a_lat[elem_idx(l, k, N, W) +: W];
            assign b_vec[k*W +: W] = b_lat[elem_idx(k, l, N, W) +: W];
        end

        skew_lane #(.LANE(l), .N(N), .W(W)) u_a_lane (
            .clock      (clock),
            .reset      (reset),
            .start      (lane_start),
            .feed       (lane_feed),
            .vec        (a_vec),
            .edge_data  (a_edge[l*W +: W]),
            .edge_valid (a_edge_valid[l])
        );

        skew_lane #(.LANE(l), .N(N), .W(W)) u_b_lane (
            .clock      (clock),
            .reset      (reset),
            .start      (lane_start),
            .feed       (lane_feed),
            .vec        (b_vec),
            .edge_data  (b_edge[l*W +: W]),
            .edge_valid (b_edge_valid[l])
        );
    end

endmodule
